ethernet_receive_que_slot: RTL and testbench

- One receive-queue slot that sits directly downstream of the Ethernet packet parser; one instance per slot index.
- Buffers the parser's per-byte packet stream speculatively, then commits the frame on good_packet or discards it (rewinds) on bad_packet.
- Advertises slot_enable so the parser selects it only when a maximum-size frame fits.
- Presents committed frames to the switch fabric over a ready/valid byte stream with length and last flag.

---
 rtl/ethernet_receive_que_slot.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ethernet_receive_que_slot.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_receive_que_slot.sv
// ---------------------------------------------------------------------------
// ethernet_receive_que_slot
//
// One receive-queue slot placed directly after the Ethernet packet parser.
// Bytes from the parser are buffered speculatively. good_packet commits the
// frame and pushes its length into a small descriptor FIFO. bad_packet, or
// any good_packet that cannot be committed, rewinds the write pointer to the
// last commit point. Committed frames are streamed to the switch fabric over
// a ready/valid byte interface with a last flag.
//
// Optional build macro:
//   ETHERNET_RECEIVE_SLOT_STRIP_FCS_EN - when defined, the 4 trailing FCS
//   bytes of every committed frame are discarded. They are never streamed,
//   and the reported length excludes them.
//
// Ports:
//   clock              single clock
//   reset              synchronous, active-high
//   packet_data        byte from the parser
//   packet_data_valid  packet_data valid this cycle
//   good_packet        1-cycle pulse, frame CRC good
//   bad_packet         1-cycle pulse, frame CRC bad
//   slot_enable        slot can accept a maximum-size frame (registered)
//   frame_available    at least one committed frame queued
//   frame_length       byte count of the head frame (0 when none)
//   read_data          stream byte
//   read_valid         read_data valid
//   read_last          final byte of the frame, qualified by read_valid
//   read_ready         consumer accepts the byte
//   frame_dropped      1-cycle pulse, frame discarded
// ---------------------------------------------------------------------------
module ethernet_receive_que_slot #(
   parameter int unsigned BUFFER_DEPTH      = 4096,
   parameter int unsigned MAX_FRAME_BYTES   = 1522,
   parameter int unsigned LENGTH_FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  packet_data,
   input  logic        packet_data_valid,
   input  logic        good_packet,
   input  logic        bad_packet,
   output logic        slot_enable,
   output logic        frame_available,
   output logic [15:0] frame_length,
   output logic [7:0]  read_data,
   output logic        read_valid,
   output logic        read_last,
   input  logic        read_ready,
   output logic        frame_dropped
);

   localparam int unsigned AW = $clog2(BUFFER_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned FW = $clog2(LENGTH_FIFO_DEPTH);
   localparam int unsigned DW = FW + 1;

   localparam logic [PW-1:0] PTR_ONE    = PW'(32'd1);
   localparam logic [PW-1:0] PTR_FCS    = PW'(32'd4);
   localparam logic [PW-1:0] USED_FULL  = PW'(BUFFER_DEPTH);
   localparam logic [PW-1:0] USED_LIMIT = PW'(BUFFER_DEPTH - MAX_FRAME_BYTES);
   localparam logic [AW-1:0] ADDR_ONE   = AW'(32'd1);
   localparam logic [DW-1:0] DESC_ONE   = DW'(32'd1);

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_PRIME  = 2'd1,
      R_STREAM = 2'd2
   } rstate_e;

   // storage
   logic [7:0]    mem_q      [BUFFER_DEPTH];
   logic [15:0]   desc_mem_q [LENGTH_FIFO_DEPTH];

   // write side
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [15:0]   frame_count_q, frame_count_d;
   logic          overflow_q, overflow_d;
   logic [DW-1:0] desc_wr_q;
   logic          slot_enable_q;
   logic          frame_dropped_q;

   // read side
   rstate_e       state_q;
   logic [PW-1:0] rd_ptr_q;
   logic [AW-1:0] fetch_ptr_q;
   logic [15:0]   fetch_left_q;
   logic [15:0]   remaining_q;
   logic [DW-1:0] desc_rd_q;
   logic [7:0]    ram_data_q;
   logic          ram_vld_q, ram_last_q;
   logic [7:0]    out_data_q, skid_data_q;
   logic          out_vld_q, skid_vld_q;
   logic          out_last_q, skid_last_q;

   // combinational
   logic [PW-1:0] used_s;
   logic          buf_full_s;
   logic [DW-1:0] desc_cnt_s;
   logic          desc_full_s, desc_empty_s;
   logic          wr_en_s;
   logic [PW-1:0] wr_ptr_adv_s;
   logic [15:0]   fc_adv_s;
   logic          ovf_adv_s;
   logic          too_short_s;
   logic [15:0]   commit_len_s;
   logic [PW-1:0] commit_ptr_s;
   logic          desc_push_s;
   logic          drop_s;
   logic          slot_en_d_s;
   logic          accept_s;
   logic [1:0]    occ_s;
   logic          room_s;
   logic [15:0]   head_len_s;
   logic          fetch_en_s;
   logic [AW-1:0] fetch_addr_s;
   logic          last_accept_s;

   // Occupancy of the byte buffer and of the descriptor FIFO.
   always_comb begin
      used_s       = wr_ptr_q - rd_ptr_q;
      buf_full_s   = (used_s == USED_FULL);
      desc_cnt_s   = desc_wr_q - desc_rd_q;
      desc_full_s  = desc_cnt_s[FW];
      desc_empty_s = (desc_wr_q == desc_rd_q);
      head_len_s   = desc_mem_q[desc_rd_q[FW-1:0]];
   end

   // Write, commit and rewind decisions for this cycle.
   always_comb begin
      wr_en_s      = packet_data_valid && !buf_full_s;
      wr_ptr_adv_s = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      if (wr_en_s && (frame_count_q != 16'hFFFF)) begin
         fc_adv_s = frame_count_q + 16'd1;
      end else begin
         fc_adv_s = frame_count_q;
      end
      ovf_adv_s = overflow_q || (packet_data_valid && buf_full_s);
`ifdef ETHERNET_RECEIVE_SLOT_STRIP_FCS_EN
      // The FCS is trimmed at commit time by pulling the write pointer back.
      too_short_s  = (fc_adv_s <= 16'd4);
      commit_len_s = fc_adv_s - 16'd4;
      commit_ptr_s = wr_ptr_adv_s - PTR_FCS;
`else
      too_short_s  = (fc_adv_s == 16'd0);
      commit_len_s = fc_adv_s;
      commit_ptr_s = wr_ptr_adv_s;
`endif
      wr_ptr_d      = wr_ptr_adv_s;
      commit_ptr_d  = commit_ptr_q;
      frame_count_d = fc_adv_s;
      overflow_d    = ovf_adv_s;
      desc_push_s   = 1'b0;
      drop_s        = 1'b0;
      if (bad_packet) begin
         // bad wins over a simultaneous good
         wr_ptr_d      = commit_ptr_q;
         frame_count_d = 16'd0;
         overflow_d    = 1'b0;
         drop_s        = 1'b1;
      end else if (good_packet) begin
         frame_count_d = 16'd0;
         overflow_d    = 1'b0;
         if (ovf_adv_s || desc_full_s || too_short_s) begin
            wr_ptr_d = commit_ptr_q;
            drop_s   = 1'b1;
         end else begin
            wr_ptr_d     = commit_ptr_s;
            commit_ptr_d = commit_ptr_s;
            desc_push_s  = 1'b1;
         end
      end else begin
         wr_ptr_d = wr_ptr_adv_s;
      end
      // Evaluated on current registers, so freed space shows up one cycle later.
      slot_en_d_s = (used_s <= USED_LIMIT) && !desc_full_s && (frame_count_q == 16'd0);
   end

   // Write-side state: pointers, frame accounting, descriptor push, status.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q        <= {PW{1'b0}};
         commit_ptr_q    <= {PW{1'b0}};
         frame_count_q   <= 16'd0;
         overflow_q      <= 1'b0;
         desc_wr_q       <= {DW{1'b0}};
         slot_enable_q   <= 1'b0;
         frame_dropped_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         commit_ptr_q    <= commit_ptr_d;
         frame_count_q   <= frame_count_d;
         overflow_q      <= overflow_d;
         desc_wr_q       <= desc_push_s ? (desc_wr_q + DESC_ONE) : desc_wr_q;
         slot_enable_q   <= slot_en_d_s;
         frame_dropped_q <= drop_s;
      end
   end

   // Byte storage write port.
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= packet_data;
      end
   end

   // Descriptor storage write port.
   always_ff @(posedge clock) begin
      if (desc_push_s) begin
         desc_mem_q[desc_wr_q[FW-1:0]] <= commit_len_s;
      end
   end

   // Prefetch control: keep at most two bytes between RAM output, output
   // register and skid register so the stream can run at one byte per cycle.
   always_comb begin
      accept_s = out_vld_q && read_ready;
      occ_s    = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
      room_s   = ((occ_s - {1'b0, accept_s}) < 2'd2);
      case (state_q)
         R_IDLE: begin
            fetch_en_s   = !desc_empty_s;
            fetch_addr_s = rd_ptr_q[AW-1:0];
         end
         R_PRIME, R_STREAM: begin
            fetch_en_s   = (fetch_left_q != 16'd0) && room_s;
            fetch_addr_s = fetch_ptr_q;
         end
         default: begin
            fetch_en_s   = 1'b0;
            fetch_addr_s = rd_ptr_q[AW-1:0];
         end
      endcase
      last_accept_s = (state_q == R_STREAM) && accept_s && (remaining_q == 16'd1);
   end

   // Byte storage synchronous read port.
   always_ff @(posedge clock) begin
      if (fetch_en_s) begin
         ram_data_q <= mem_q[fetch_addr_s];
      end
   end

   // Read FSM with prefetch pipeline, skid register and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= R_IDLE;
         rd_ptr_q     <= {PW{1'b0}};
         fetch_ptr_q  <= {AW{1'b0}};
         fetch_left_q <= 16'd0;
         remaining_q  <= 16'd0;
         desc_rd_q    <= {DW{1'b0}};
         ram_vld_q    <= 1'b0;
         ram_last_q   <= 1'b0;
         out_data_q   <= 8'd0;
         out_vld_q    <= 1'b0;
         out_last_q   <= 1'b0;
         skid_data_q  <= 8'd0;
         skid_vld_q   <= 1'b0;
         skid_last_q  <= 1'b0;
      end else begin
         case (state_q)
            R_IDLE: begin
               out_vld_q  <= 1'b0;
               skid_vld_q <= 1'b0;
               if (!desc_empty_s) begin
                  remaining_q  <= head_len_s;
                  fetch_ptr_q  <= rd_ptr_q[AW-1:0] + ADDR_ONE;
                  fetch_left_q <= head_len_s - 16'd1;
                  ram_vld_q    <= 1'b1;
                  ram_last_q   <= (head_len_s == 16'd1);
                  state_q      <= R_PRIME;
               end else begin
                  ram_vld_q <= 1'b0;
               end
            end
            R_PRIME, R_STREAM: begin
               if (fetch_en_s) begin
                  fetch_ptr_q  <= fetch_ptr_q + ADDR_ONE;
                  fetch_left_q <= fetch_left_q - 16'd1;
                  ram_vld_q    <= 1'b1;
                  ram_last_q   <= (fetch_left_q == 16'd1);
               end else begin
                  ram_vld_q <= 1'b0;
               end
               // Output register refills from the skid first, then from RAM;
               // RAM data that cannot go to a held output parks in the skid.
               if (!out_vld_q || accept_s) begin
                  if (skid_vld_q) begin
                     out_data_q  <= skid_data_q;
                     out_last_q  <= skid_last_q;
                     out_vld_q   <= 1'b1;
                     skid_data_q <= ram_data_q;
                     skid_last_q <= ram_last_q;
                     skid_vld_q  <= ram_vld_q;
                  end else if (ram_vld_q) begin
                     out_data_q <= ram_data_q;
                     out_last_q <= ram_last_q;
                     out_vld_q  <= 1'b1;
                  end else begin
                     out_vld_q <= 1'b0;
                  end
               end else if (ram_vld_q) begin
                  skid_data_q <= ram_data_q;
                  skid_last_q <= ram_last_q;
                  skid_vld_q  <= 1'b1;
               end else begin
                  skid_vld_q <= skid_vld_q;
               end
               if (accept_s) begin
                  rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                  remaining_q <= remaining_q - 16'd1;
               end else begin
                  remaining_q <= remaining_q;
               end
               if (last_accept_s) begin
                  desc_rd_q <= desc_rd_q + DESC_ONE;
                  state_q   <= R_IDLE;
               end else if (state_q == R_PRIME) begin
                  state_q <= R_STREAM;
               end else begin
                  state_q <= state_q;
               end
            end
            default: begin
               state_q <= R_IDLE;
            end
         endcase
      end
   end

   assign slot_enable     = slot_enable_q;
   assign frame_available = !desc_empty_s;
   assign frame_length    = desc_empty_s ? 16'd0 : head_len_s;
   assign read_data       = out_data_q;
   assign read_valid      = out_vld_q;
   assign read_last       = out_last_q;
   assign frame_dropped   = frame_dropped_q;

endmodule

// File: tb/tb_ethernet_receive_que_slot.sv
module tb_ethernet_receive_que_slot;

   localparam int DEPTH = 2048;
   localparam int MAXF  = 1522;
   localparam int FD    = 8;
`ifdef ETHERNET_RECEIVE_SLOT_STRIP_FCS_EN
   localparam int FCS = 4;
`else
   localparam int FCS = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  packet_data = 8'd0;
   logic        packet_data_valid = 1'b0;
   logic        good_packet = 1'b0;
   logic        bad_packet = 1'b0;
   logic        slot_enable;
   logic        frame_available;
   logic [15:0] frame_length;
   logic [7:0]  read_data;
   logic        read_valid;
   logic        read_last;
   logic        read_ready = 1'b0;
   logic        frame_dropped;

   always #5 clock = ~clock;

   ethernet_receive_que_slot #(
      .BUFFER_DEPTH(DEPTH), .MAX_FRAME_BYTES(MAXF), .LENGTH_FIFO_DEPTH(FD)
   ) dut (
      .clock(clock), .reset(reset), .packet_data(packet_data),
      .packet_data_valid(packet_data_valid), .good_packet(good_packet),
      .bad_packet(bad_packet), .slot_enable(slot_enable),
      .frame_available(frame_available), .frame_length(frame_length),
      .read_data(read_data), .read_valid(read_valid), .read_last(read_last),
      .read_ready(read_ready), .frame_dropped(frame_dropped)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: committed bytes not yet consumed, committed lengths,
   // bytes of the frame being received, overflow flag.
   logic [7:0] mdl_bytes[$];
   int         mdl_lens[$];
   int         mdl_head_done = 0;
   logic [7:0] mdl_pend[$];
   bit         mdl_ovf = 1'b0;
   bit         exp_drop = 1'b0;
   bit         exp_se = 1'b0;
   int         rr_mode = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_last = 1'b0;
   int         drop_seen = 0;

   task automatic step(input bit v, input logic [7:0] d, input bit g, input bit b, input bit rst);
      bit acc;
      int used_pre;
      int nfr_pre;
      case (rr_mode)
         0:       read_ready = 1'b1;
         1:       read_ready = 1'($urandom_range(0, 1));
         2:       read_ready = ~read_ready;
         default: read_ready = 1'b0;
      endcase
      packet_data_valid = v; packet_data = d; good_packet = g; bad_packet = b; reset = rst;
      acc = read_valid && read_ready;
      if (prev_stall) begin
         check_eq("hold_valid", read_valid, 1);
         check_eq("hold_data", read_data, prev_data);
         check_eq("hold_last", read_last, prev_last);
      end
      if (read_valid && mdl_lens.size() == 0)
         check_eq("spurious_valid", read_valid, 0);
      else if (!read_valid && mdl_lens.size() != 0 && mdl_head_done > 0)
         check_eq("bubble", read_valid, 1);
      if (acc && !rst && mdl_bytes.size() > 0) begin
         check_eq("rd_data", read_data, mdl_bytes[0]);
         check_eq("rd_last", read_last, (mdl_head_done == mdl_lens[0] - 1));
      end
      prev_stall = !rst && read_valid && !read_ready;
      prev_data  = read_data;
      prev_last  = read_last;
      if (rst) begin
         mdl_bytes.delete(); mdl_lens.delete(); mdl_pend.delete();
         mdl_head_done = 0; mdl_ovf = 1'b0; exp_drop = 1'b0; exp_se = 1'b0;
      end else begin
         used_pre = mdl_bytes.size() + mdl_pend.size();
         nfr_pre  = mdl_lens.size();
         exp_se   = (DEPTH - used_pre >= MAXF) && (nfr_pre < FD) && (mdl_pend.size() == 0);
         exp_drop = 1'b0;
         if (v) begin
            if (used_pre < DEPTH) mdl_pend.push_back(d);
            else mdl_ovf = 1'b1;
         end
         if (b) begin
            exp_drop = 1'b1;
            mdl_pend.delete(); mdl_ovf = 1'b0;
         end else if (g) begin
            if (mdl_ovf || nfr_pre == FD || mdl_pend.size() <= FCS) begin
               exp_drop = 1'b1;
            end else begin
               repeat (FCS) void'(mdl_pend.pop_back());
               mdl_lens.push_back(mdl_pend.size());
               foreach (mdl_pend[i]) mdl_bytes.push_back(mdl_pend[i]);
            end
            mdl_pend.delete(); mdl_ovf = 1'b0;
         end
         if (acc && mdl_bytes.size() > 0) begin
            void'(mdl_bytes.pop_front());
            mdl_head_done++;
            if (mdl_head_done == mdl_lens[0]) begin
               void'(mdl_lens.pop_front());
               mdl_head_done = 0;
            end
         end
      end
      @(posedge clock);
      @(negedge clock);
      check_eq("frame_available", frame_available, (mdl_lens.size() != 0));
      check_eq("frame_length", frame_length, (mdl_lens.size() != 0) ? 32'(mdl_lens[0]) : 32'd0);
      check_eq("frame_dropped", frame_dropped, exp_drop);
      check_eq("slot_enable", slot_enable, exp_se);
      if (frame_dropped) drop_seen++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // kind: 0 good after data, 1 good on last byte, 2 bad after data, 3 good+bad
   task automatic send_frame(input int len, input int kind, input bit rnd, input bit gaps);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(i);
         if (gaps) while ($urandom_range(0, 3) == 0) idle(1);
         if (i == len - 1 && kind == 1) step(1'b1, d, 1'b1, 1'b0, 1'b0);
         else step(1'b1, d, 1'b0, 1'b0, 1'b0);
      end
      case (kind)
         0: step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
         1: if (len == 0) step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
         2: step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
         default: step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      endcase
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (mdl_lens.size() != 0 && n < max_cycles) begin
         idle(1);
         n++;
      end
      check_eq("drain_timeout", mdl_lens.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int drops0;
      int n;
      int k;
      @(negedge clock);
      rr_mode = 0;
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      check_eq("rst_read_valid", read_valid, 0);
      check_eq("rst_read_last", read_last, 0);
      check_eq("rst_read_data", read_data, 0);
      check_eq("rst_frame_avail", frame_available, 0);
      check_eq("rst_frame_len", frame_length, 0);
      check_eq("rst_dropped", frame_dropped, 0);
      check_eq("rst_slot_enable", slot_enable, 0);
      idle(1);
      check_eq("post_rst_slot_enable", slot_enable, 1);

      // 64 incrementing bytes, commit, full-rate stream
      send_frame(64, 0, 1'b0, 1'b0);
      check_eq("t1_avail", frame_available, 1);
      check_eq("t1_len", frame_length, 64 - FCS);
      lat = 0;
      while (!read_valid && lat < 8) begin idle(1); lat++; end
      check_eq("t1_first_valid_latency", lat, 2);
      drain(200);

      // bad frame rewinds, then a good frame streams
      drops0 = drop_seen;
      send_frame(100, 2, 1'b0, 1'b0);
      idle(3);
      check_eq("t2_drop_count", drop_seen - drops0, 1);
      check_eq("t2_no_frame", frame_available, 0);
      send_frame(64, 1, 1'b1, 1'b1);
      drain(200);

      // large unread frame blocks slot_enable until enough is streamed
      rr_mode = 3;
      send_frame(1500, 0, 1'b1, 1'b0);
      idle(2);
      check_eq("t3_slot_blocked", slot_enable, 0);
      rr_mode = 0;
      drain(2000);
      idle(1);
      check_eq("t3_slot_free", slot_enable, 1);

      // overflow: more bytes than the buffer holds
      drops0 = drop_seen;
      send_frame(2100, 0, 1'b0, 1'b0);
      idle(1);
      check_eq("t4_overflow_drop", drop_seen - drops0, 1);
      check_eq("t4_no_frame", frame_available, 0);

      // fill the descriptor FIFO, then drain with toggling ready
      rr_mode = 3;
      for (int f = 0; f < FD; f++) send_frame(64, 0, 1'b1, 1'b0);
      idle(2);
      check_eq("t5_desc_full_slot", slot_enable, 0);
      drops0 = drop_seen;
      send_frame(10, 0, 1'b1, 1'b0);
      check_eq("t5_desc_full_drop", drop_seen - drops0, 1);
      rr_mode = 2;
      drain(3000);

      // reset in the middle of frame 2 of 3
      rr_mode = 3;
      for (int f = 0; f < 3; f++) send_frame(30, 0, 1'b1, 1'b0);
      rr_mode = 0;
      n = 0;
      while (!(mdl_lens.size() == 2 && mdl_head_done >= 5) && n < 500) begin idle(1); n++; end
      check_eq("t6_reached_frame2", (n < 500), 1);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      check_eq("t6_read_valid", read_valid, 0);
      check_eq("t6_read_last", read_last, 0);
      check_eq("t6_read_data", read_data, 0);
      check_eq("t6_frame_avail", frame_available, 0);
      check_eq("t6_frame_len", frame_length, 0);
      check_eq("t6_slot_in_reset", slot_enable, 0);
      idle(1);
      check_eq("t6_slot_after", slot_enable, 1);
      send_frame(20, 0, 1'b1, 1'b0);
      drain(200);

      // randomized traffic
      for (int f = 0; f < 60; f++) begin
         k = $urandom_range(0, 9);
         rr_mode = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
         send_frame($urandom_range(0, 120), (k < 6) ? 0 : (k < 8) ? 1 : (k < 9) ? 2 : 3, 1'b1, 1'b1);
         idle($urandom_range(0, 3));
      end
      rr_mode = 0;
      drain(6000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
